shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined successor to the single-cycle shifter in the RISC-V execute path. It performs logical-left, logical-right, arithmetic-right and (optionally) rotate-right on a WIDTH-bit operand. The log2(WIDTH) mux levels are split across STAGES registered stages, and a valid/ready handshake provides backpressure. A result tag passes through so writeback can match results to destination registers.

## Interface
- WIDTH, 32: operand width; power of two, at least 8.
- STAGES, 2: pipeline depth; 1 ≤ STAGES ≤ log2(WIDTH).
- TAG_W, 5: width of the pass-through tag (rd index).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous; drops all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  pipeline can accept this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  8  shift amount; only the low log2(WIDTH) bits are used.
- in_op  in  2  operation code: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  tag returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  the op was not supported in this build; out_data is 0.

## Operation
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Shift amount:
  - The amount is masked to log2(WIDTH) bits, per RISC-V semantics.
  - Example: shamt 0x21 with WIDTH=32 shifts by 1.
- Shift levels: level k shifts by 2^k. Levels are assigned to stages in order, with ceil(log2(WIDTH)/STAGES) levels per stage; the last stage takes the remainder.
- Per-stage register contents: valid, partial data, remaining shamt bits, op, sign bit (the original in_data[WIDTH-1]), tag, illegal.
- SRA fills with the captured sign bit. SLL and SRL fill with 0. ROR wraps the bits around.
- Shamt 0 returns in_data unchanged for every op.
- Stage advance rule: stage i loads when it is empty, or when its contents move forward in the same cycle. The ready chain is combinational from out_ready back to in_ready, so a full pipeline with out_ready=1 sustains 1 op per cycle.
- The pipeline preserves issue order. It never drops or duplicates an operation.
- Flush:
  - flush clears every stage valid on the next edge.
  - in_ready is forced 0 during flush, so no new operation is accepted in that cycle.
  - An output handshake in the same cycle as flush still completes.

## Timing
- Latency: an operation accepted at edge N appears on out_valid after edge N+STAGES, provided no stall occurs.
- Throughput: 1 op per cycle.
- Stall: while out_valid && !out_ready, out_data, out_tag and out_illegal hold stable. Upstream stages fill any bubbles, then in_ready drops.
- Reset: asynchronous assertion clears all valids immediately. Output reset values:
  - out_valid=0, out_data=0, out_tag=0, out_illegal=0.
  - in_ready=1 once reset deasserts.
  - Operations in flight when reset asserts are lost.
- Simultaneous events:
  - flush and rst_n low together: reset wins.
  - in_valid with a full, stalled pipeline: the input is not accepted, and the upstream source holds it.

## Configuration
- SHIFT_PIPE_ROTATE_EN defined: op 11 performs a rotate-right by the masked shamt, and out_illegal=0.
- Not defined: there is no rotate logic. Op 11 flows through the pipeline with normal latency and ordering, then emerges with out_data=0 and out_illegal=1.

## Structure
- shift_pkg holds the op enum (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR) and the 8-bit shamt width constant.
- Sub-module shift_stage is generated once per stage. It takes a LEVEL_LO/LEVEL_HI range, holds the combinational mux levels plus the stage register, and handles its own valid/ready.

## Test plan
- SRA basic (WIDTH=32, STAGES=2): SRA 0x80000000 by 4, out_ready=1 → out_data=0xF8000000 and out_valid exactly 2 cycles after acceptance, out_tag echoed.
- Shamt masking: SLL 0x00000001 with shamt 0x21 → 0x00000002. SRL 0xFFFFFFFF with shamt 0 → 0xFFFFFFFF.
- Backpressure: issue 4 back-to-back ops with out_ready=0 → in_ready drops after 2 are accepted. Raise out_ready → all 4 results arrive in order with no loss.
- Flush: 2 ops in flight, pulse flush one cycle → no out_valid follows. The next op issued afterwards completes with normal latency.
- Rotate, macro on: ROR 0x00000001 by 1 → 0x80000000, out_illegal=0. Macro off: the same stimulus → out_data=0, out_illegal=1.
- Reset mid-operation: assert rst_n=0 with 2 ops in flight → out_valid=0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the pipelined shifter.
// Build option: SHIFT_PIPE_ROTATE_EN enables the rotate-right datapath.
package shift_pkg;

    // Operation code carried alongside each in-flight operand.
    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    // Width of the raw shift-amount field at the pipeline input.
    localparam int SHAMT_W = 8;

    // Mux levels handled by each stage; the last stage may get fewer.
    function automatic int levels_per_stage(input int log2w, input int stages);
        return (log2w + stages - 1) / stages;
    endfunction

    // Highest level owned by stage idx, clamped to the last real level.
    // A result below the stage's low level means the stage is a plain register.
    function automatic int stage_level_hi(input int idx, input int lps, input int log2w);
        int hi;
        hi = (idx + 1) * lps - 1;
        if (hi > log2w - 1) hi = log2w - 1;
        return hi;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of shift_pipe: mux levels LEVEL_LO..LEVEL_HI followed by
// a register slice with its own valid/ready. Build option: SHIFT_PIPE_ROTATE_EN.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SHW      = 5,
    parameter int TAG_W    = 5,
    parameter int LEVEL_LO = 0,
    parameter int LEVEL_HI = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    // upstream side
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SHW-1:0]   up_shamt,
    input  shift_op_e        up_op,
    input  logic             up_sign,
    input  logic [TAG_W-1:0] up_tag,
    input  logic             up_illegal,
    // downstream side
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic [SHW-1:0]   dn_shamt,
    output shift_op_e        dn_op,
    output logic             dn_sign,
    output logic [TAG_W-1:0] dn_tag,
    output logic             dn_illegal
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    shift_op_e        op_q;
    logic             sign_q;
    logic [TAG_W-1:0] tag_q;
    logic             illegal_q;
    logic [WIDTH-1:0] shifted;

    // Fixed shift by amt (a power of two below WIDTH) for the given op.
    // SRA fills from the sign captured at entry, not from the partial data,
    // since earlier levels may already have moved the MSB.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input shift_op_e        op,
        input logic             sign,
        input int               amt
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] r;
        fill = ~({WIDTH{1'b1}} >> amt);
        case (op)
            SHIFT_SLL: r = d << amt;
            SHIFT_SRL: r = d >> amt;
            SHIFT_SRA: r = (d >> amt) | (sign ? fill : '0);
`ifdef SHIFT_PIPE_ROTATE_EN
            SHIFT_ROR: r = (d >> amt) | (d << (WIDTH - amt));
`else
            // no rotate hardware: operand was zeroed at entry, just carry it
            SHIFT_ROR: r = d;
`endif
            default:   r = d;
        endcase
        return r;
    endfunction

    // Apply this stage's share of the log2(WIDTH) mux levels.
    always_comb begin
        shifted = up_data;
        for (int k = LEVEL_LO; k <= LEVEL_HI; k++) begin
            if (up_shamt[k]) shifted = shift_level(shifted, up_op, up_sign, 1 << k);
        end
    end

    // Load when empty or when the current contents leave this cycle.
    assign up_ready = !valid_q || dn_ready;

    // Stage valid: flush empties the slice, otherwise follow the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        valid_q <= 1'b0;
        else if (flush)    valid_q <= 1'b0;
        else if (up_ready) valid_q <= up_valid;
    end

    // Payload only moves on a real load so a stalled result stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            shamt_q   <= '0;
            op_q      <= SHIFT_SLL;
            sign_q    <= 1'b0;
            tag_q     <= '0;
            illegal_q <= 1'b0;
        end else if (up_ready && up_valid && !flush) begin
            data_q    <= shifted;
            shamt_q   <= up_shamt;
            op_q      <= up_op;
            sign_q    <= up_sign;
            tag_q     <= up_tag;
            illegal_q <= up_illegal;
        end
    end

    assign dn_valid   = valid_q;
    assign dn_data    = data_q;
    assign dn_shamt   = shamt_q;
    assign dn_op      = op_q;
    assign dn_sign    = sign_q;
    assign dn_tag     = tag_q;
    assign dn_illegal = illegal_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/(ROR) shifter with valid/ready backpressure and a
// pass-through tag. Build option: SHIFT_PIPE_ROTATE_EN enables rotate-right;
// without it op 11 travels the pipe and exits with out_illegal=1, data 0.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam int LPS   = levels_per_stage(LOG2W, STAGES);

    // Index 0 is the pipe input, index i+1 the register of stage i.
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0]             rdy_pipe;
    logic [STAGES:0][WIDTH-1:0]  data_pipe;
    logic [STAGES:0][LOG2W-1:0]  shamt_pipe;
    shift_op_e [STAGES:0]        op_pipe;
    logic [STAGES:0]             sign_pipe;
    logic [STAGES:0][TAG_W-1:0]  tag_pipe;
    logic [STAGES:0]             ill_pipe;

    logic in_illegal;
    logic unused_shamt;
    logic unused_tail;

    // Decode ops this build cannot execute; they are zeroed on entry so the
    // result emerges as 0 without any extra output muxing.
    always_comb begin
`ifdef SHIFT_PIPE_ROTATE_EN
        in_illegal = 1'b0;
`else
        in_illegal = (in_op == SHIFT_ROR);
`endif
    end

    // Flush blocks acceptance for the cycle it is asserted.
    assign vld_pipe[0]   = in_valid && !flush;
    assign in_ready      = rdy_pipe[0] && !flush;
    assign data_pipe[0]  = in_illegal ? '0 : in_data;
    assign shamt_pipe[0] = in_shamt[LOG2W-1:0];
    assign op_pipe[0]    = shift_op_e'(in_op);
    assign sign_pipe[0]  = data_pipe[0][WIDTH-1];
    assign tag_pipe[0]   = in_tag;
    assign ill_pipe[0]   = in_illegal;

    // Upper shamt bits are architecturally ignored (RISC-V masking).
    assign unused_shamt = ^in_shamt;

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            localparam int LO = i * LPS;
            localparam int HI = stage_level_hi(i, LPS, LOG2W);

            shift_stage #(
                .WIDTH    (WIDTH),
                .SHW      (LOG2W),
                .TAG_W    (TAG_W),
                .LEVEL_LO (LO),
                .LEVEL_HI (HI)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush      (flush),
                .up_valid   (vld_pipe[i]),
                .up_ready   (rdy_pipe[i]),
                .up_data    (data_pipe[i]),
                .up_shamt   (shamt_pipe[i]),
                .up_op      (op_pipe[i]),
                .up_sign    (sign_pipe[i]),
                .up_tag     (tag_pipe[i]),
                .up_illegal (ill_pipe[i]),
                .dn_valid   (vld_pipe[i+1]),
                .dn_ready   (rdy_pipe[i+1]),
                .dn_data    (data_pipe[i+1]),
                .dn_shamt   (shamt_pipe[i+1]),
                .dn_op      (op_pipe[i+1]),
                .dn_sign    (sign_pipe[i+1]),
                .dn_tag     (tag_pipe[i+1]),
                .dn_illegal (ill_pipe[i+1])
            );
        end
    endgenerate

    // Ready chain closes on the consumer; combinational back to in_ready.
    assign rdy_pipe[STAGES] = out_ready;

    assign out_valid   = vld_pipe[STAGES];
    assign out_data    = data_pipe[STAGES];
    assign out_tag     = tag_pipe[STAGES];
    assign out_illegal = ill_pipe[STAGES];

    // Routing fields have no consumer past the final stage.
    assign unused_tail = ^{shamt_pipe[STAGES], op_pipe[STAGES], sign_pipe[STAGES]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=32, STAGES=2, TAG_W=5).
module tb_shift_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_shamt;
    logic [1:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_shamt    (in_shamt),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [7:0] sh,
                         input logic [4:0] tg);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tg;
    endtask

    // Single op with out_ready=1: presented in cycle 0, out_valid in cycle 2.
    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] d,
                           input logic [7:0] sh, input logic [4:0] tg,
                           input logic [31:0] exp_d, input logic exp_ill);
        drive(op, d, sh, tg);
        #1 check({name, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({name, " early valid"}, 32'(out_valid), 32'd0);
        tick();
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " data"}, out_data, exp_d);
        check({name, " tag"}, 32'(out_tag), 32'(tg));
        check({name, " illegal"}, 32'(out_illegal), 32'(exp_ill));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = 2'b00;
        in_tag    = '0;
        out_ready = 1'b1;

        // reset values
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_tag", 32'(out_tag), 32'd0);
        check("rst out_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        #1 check("post-rst in_ready", 32'(in_ready), 32'd1);
        tick();

        // basic function and boundaries
        run_one("sra basic", 2'b10, 32'h8000_0000, 8'd4, 5'd7, 32'hF800_0000, 1'b0);
        run_one("sll mask", 2'b00, 32'h0000_0001, 8'h21, 5'd3, 32'h0000_0002, 1'b0);
        run_one("srl zero", 2'b01, 32'hFFFF_FFFF, 8'd0, 5'd4, 32'hFFFF_FFFF, 1'b0);
        run_one("sra 31", 2'b10, 32'h8000_0000, 8'd31, 5'd5, 32'hFFFF_FFFF, 1'b0);
        run_one("sra pos 31", 2'b10, 32'h7FFF_FFFF, 8'd31, 5'd6, 32'h0000_0000, 1'b0);
        run_one("sll 31", 2'b00, 32'h0000_0001, 8'd31, 5'd8, 32'h8000_0000, 1'b0);
        run_one("sra zero", 2'b10, 32'h8000_0001, 8'd0, 5'd9, 32'h8000_0001, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
        run_one("ror 1", 2'b11, 32'h0000_0001, 8'd1, 5'd12, 32'h8000_0000, 1'b0);
        run_one("ror 8", 2'b11, 32'h1234_5678, 8'd8, 5'd13, 32'h7812_3456, 1'b0);
`else
        run_one("ror 1", 2'b11, 32'h0000_0001, 8'd1, 5'd12, 32'h0000_0000, 1'b1);
        run_one("ror 8", 2'b11, 32'h1234_5678, 8'd8, 5'd13, 32'h0000_0000, 1'b1);
`endif
        tick();

        // backpressure: two ops fill the pipe, third waits
        out_ready = 1'b0;
        drive(2'b00, 32'h0000_000F, 8'd4, 5'd1);
        #1 check("bp in_ready 1", 32'(in_ready), 32'd1);
        tick();
        drive(2'b01, 32'hF000_0000, 8'd8, 5'd2);
        #1 check("bp in_ready 2", 32'(in_ready), 32'd1);
        tick();
        drive(2'b10, 32'h9000_0000, 8'd1, 5'd3);
        #1 check("bp in_ready full", 32'(in_ready), 32'd0);
        check("bp head valid", 32'(out_valid), 32'd1);
        check("bp head data", out_data, 32'h0000_00F0);
        tick();
        check("bp stall data", out_data, 32'h0000_00F0);
        check("bp stall tag", 32'(out_tag), 32'd1);
        check("bp stall in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1 check("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp op2 tag", 32'(out_tag), 32'd2);
        check("bp op2 data", out_data, 32'h00F0_0000);
        drive(2'b00, 32'h1234_5678, 8'd16, 5'd4);
        tick();
        in_valid = 1'b0;
        check("bp op3 tag", 32'(out_tag), 32'd3);
        check("bp op3 data", out_data, 32'hC800_0000);
        tick();
        check("bp op4 tag", 32'(out_tag), 32'd4);
        check("bp op4 data", out_data, 32'h5678_0000);
        tick();
        check("bp drained", 32'(out_valid), 32'd0);

        // flush with two ops in flight
        drive(2'b00, 32'h0000_0001, 8'd1, 5'd10);
        tick();
        drive(2'b00, 32'h0000_0001, 8'd2, 5'd11);
        tick();
        drive(2'b00, 32'h0000_0001, 8'd3, 5'd12);
        flush = 1'b1;
        #1 check("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush valid 0", 32'(out_valid), 32'd0);
        tick();
        check("flush valid 1", 32'(out_valid), 32'd0);
        tick();
        check("flush valid 2", 32'(out_valid), 32'd0);
        run_one("post flush", 2'b01, 32'h8000_0000, 8'd31, 5'd14, 32'h0000_0001, 1'b0);
        tick();

        // asynchronous reset with two ops in flight
        out_ready = 1'b0;
        drive(2'b00, 32'h0000_0003, 8'd1, 5'd20);
        tick();
        drive(2'b00, 32'h0000_0003, 8'd2, 5'd21);
        tick();
        in_valid = 1'b0;
        check("pre-rst valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(out_valid), 32'd0);
        check("async rst data", out_data, 32'd0);
        check("async rst tag", 32'(out_tag), 32'd0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("rel in_ready", 32'(in_ready), 32'd1);
        tick();
        check("no stale 0", 32'(out_valid), 32'd0);
        tick();
        check("no stale 1", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
